// File: rtl/arb_pkg.sv
// Shared encodings and default parameters for the job requester and its round-robin arbiter.
package arb_pkg;

    // Requester FSM encodings; 2'b11 is unused and recovers to StIdle.
    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StReq  = 2'b01;
    localparam logic [1:0] StXfer = 2'b10;

    localparam int unsigned DefFifoDepth = 4;
    localparam int unsigned DefLenW      = 4;
    localparam int unsigned DefTimeout   = 15;

    // Round-robin arbiter encodings.
    typedef enum logic [1:0] {
        ArbIdle  = 2'b00,
        ArbGrant = 2'b01,
        ArbHold  = 2'b10
    } arb_state_e;

endpackage

// File: rtl/job_fifo.sv
// Power-of-two job queue; pointers carry one extra wrap bit so full and empty are distinct.
module job_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout    = mem[rptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/arb_requester.sv
// Queues burst jobs, requests the shared arbiter for each one and streams its beats once granted.
module arb_requester
    import arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DefFifoDepth,
    parameter int unsigned LEN_W      = DefLenW,
    parameter int unsigned TIMEOUT    = DefTimeout
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    input  logic             gnt,
    output logic             req,
    output logic             beat_valid,
    output logic             beat_last,
    output logic             busy,
    output logic             starve
);
    localparam int unsigned      WaitW   = $clog2(TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT);

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [WaitW-1:0] wait_q, wait_d, wait_inc;
    logic             req_q, req_d;
    logic             bv_q, bv_d;
    logic             bl_q, bl_d;
    logic             starve_q, starve_d;

    logic             fifo_full, fifo_empty, push, pop;
    logic [LEN_W-1:0] fifo_dout;

    // A push offered while full is dropped even if the same edge pops.
    assign push = job_valid && !fifo_full;

    job_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LEN_W)
    ) u_job_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .din   (job_len),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wait_inc = wait_q + WaitW'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        req_d    = req_q;
        bv_d     = bv_q;
        bl_d     = bl_q;
        starve_d = starve_q;
        pop      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StReq;
                    req_d   = 1'b1;
                end
            end
            StReq: begin
                if (gnt) begin
                    pop      = 1'b1;
                    cnt_d    = fifo_dout;
                    state_d  = StXfer;
                    req_d    = 1'b0;
                    bv_d     = 1'b1;
                    bl_d     = (fifo_dout == '0);
                    wait_d   = '0;
                    starve_d = 1'b0;
                end else if (wait_q != WaitMax) begin
                    wait_d = wait_inc;
                    if (wait_inc == WaitMax) starve_d = 1'b1;
                end
            end
            StXfer: begin
                if (cnt_q == '0) begin
                    bv_d = 1'b0;
                    bl_d = 1'b0;
                    if (!fifo_empty) begin
                        state_d = StReq;
                        req_d   = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                    bl_d  = (cnt_q == LEN_W'(1));
                end
            end
            default: begin
                state_d  = StIdle;
                cnt_d    = '0;
                wait_d   = '0;
                req_d    = 1'b0;
                bv_d     = 1'b0;
                bl_d     = 1'b0;
                starve_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            wait_q   <= '0;
            req_q    <= 1'b0;
            bv_q     <= 1'b0;
            bl_q     <= 1'b0;
            starve_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            req_q    <= req_d;
            bv_q     <= bv_d;
            bl_q     <= bl_d;
            starve_q <= starve_d;
        end
    end

    assign req        = req_q;
    assign beat_valid = bv_q;
    assign beat_last  = bl_q;
    assign starve     = starve_q;
    assign busy       = (state_q != StIdle) || !fifo_empty;
    assign job_ready  = !fifo_full;

endmodule
